// File: rtl/video_mnist_result_collector_pkg.sv
// Shared types and constants for the MNIST result collector.
// Holds the class-count default, index width helper and FSM states.
package video_mnist_result_collector_pkg;

  localparam int CLASS_NUM_DEF = 10;

  function automatic int class_width(input int n);
    int w;
    for (w = 1; (1 << w) < n; w++) begin
    end
    return w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_ARGMAX = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

endpackage

// File: rtl/video_mnist_result_argmax.sv
// Sequential max scan over the per-class vote counters.
// Ports: start pulse, count_array in; done, index, count out.
module video_mnist_result_argmax
  import video_mnist_result_collector_pkg::*;
#(
  parameter int CLASS_NUM   = CLASS_NUM_DEF,
  parameter int CLASS_WIDTH = class_width(CLASS_NUM_DEF),
  parameter int COUNT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [CLASS_NUM-1:0][COUNT_WIDTH-1:0] count_array,
  output logic done,
  output logic [CLASS_WIDTH-1:0] index,
  output logic [COUNT_WIDTH-1:0] count
);

  logic busy;
  logic take;
  logic [CLASS_WIDTH-1:0] idx;
  logic [CLASS_WIDTH-1:0] best_idx;
  logic [COUNT_WIDTH-1:0] best_cnt;
  logic [COUNT_WIDTH-1:0] cur;

  assign cur  = count_array[idx];
  // strict compare keeps the lowest index on ties
  assign take = cur > best_cnt;
  assign done = busy &&
    (idx == CLASS_WIDTH'(CLASS_NUM - 1));
  // index/count already include the class
  // being scanned, so done can latch them
  assign index = take ? idx : best_idx;
  assign count = take ? cur : best_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      idx      <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      idx      <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else if (busy) begin
      best_idx <= index;
      best_cnt <= count;
      if (done) busy <= 1'b0;
      else      idx  <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/video_mnist_result_collector.sv
// Per-frame class vote collector for the MNIST video stream.
// Ports: AXI4-Stream sink, window params, valid/ready result.
module video_mnist_result_collector
  import video_mnist_result_collector_pkg::*;
#(
  parameter int TUSER_WIDTH = 1,
  parameter int CLASS_NUM   = CLASS_NUM_DEF,
  parameter int CLASS_WIDTH = class_width(CLASS_NUM_DEF),
  parameter int IMG_X_WIDTH = 11,
  parameter int IMG_Y_WIDTH = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic [IMG_X_WIDTH-1:0] param_x0,
  input  logic [IMG_X_WIDTH-1:0] param_x1,
  input  logic [IMG_Y_WIDTH-1:0] param_y0,
  input  logic [IMG_Y_WIDTH-1:0] param_y1,
  input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
  input  logic s_axi4s_tlast,
  input  logic [CLASS_NUM-1:0] s_axi4s_tdata,
  input  logic s_axi4s_tvalid,
  output logic s_axi4s_tready,
  output logic [CLASS_WIDTH-1:0] m_result_class,
  output logic [COUNT_WIDTH-1:0] m_result_count,
  output logic m_result_overrun,
  output logic m_result_valid,
  input  logic m_result_ready
);

  state_t state, state_next;

  logic [IMG_X_WIDTH-1:0] x, bx;
  logic [IMG_Y_WIDTH-1:0] y, by;
  logic beat, sof, in_win, close;
  logic clear, add, start, done, ovr;
  logic [CLASS_NUM-1:0][COUNT_WIDTH-1:0] cnt;
  logic [CLASS_WIDTH-1:0] arg_index;
  logic [COUNT_WIDTH-1:0] arg_count;

  assign beat = s_axi4s_tvalid & s_axi4s_tready;
  assign sof  = s_axi4s_tuser[0];
  // position of the beat on the bus now
  assign bx = sof ? '0 : x;
  assign by = sof ? '0 : y;

  assign in_win = (bx >= param_x0) &&
                  (bx <= param_x1) &&
                  (by >= param_y0) &&
                  (by <= param_y1);
  assign close = s_axi4s_tlast &&
                 (by == param_y1);

  assign clear = beat && sof &&
    (state == ST_IDLE || state == ST_ACCUM);
  assign add = beat && in_win &&
    (clear || state == ST_ACCUM);

  assign m_result_valid   = (state == ST_OUTPUT);
  assign m_result_overrun = ovr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s_axi4s_tready <= 1'b0;
    else       s_axi4s_tready <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (beat) begin
      if (s_axi4s_tlast) begin
        x <= '0;
        y <= by + 1'b1;
      end else begin
        x <= bx + 1'b1;
        y <= by;
      end
    end
  end

  // a start-of-frame beat restarts the tally from itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < CLASS_NUM; i++) begin
        if (clear)
          cnt[i] <= (add && s_axi4s_tdata[i]) ?
            COUNT_WIDTH'(1) : '0;
        else if (add && s_axi4s_tdata[i] &&
                 cnt[i] != '1)
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (beat && sof) begin
          start      = close;
          state_next = close ? ST_ARGMAX : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat && close) begin
          start      = 1'b1;
          state_next = ST_ARGMAX;
        end
      end
      ST_ARGMAX: begin
        if (done) state_next = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (m_result_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_result_class <= '0;
      m_result_count <= '0;
    end else if (state == ST_ARGMAX && done) begin
      m_result_class <= arg_index;
      m_result_count <= arg_count;
    end
  end

  // a skip seen in the handshake cycle belongs to the next result
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovr <= 1'b0;
    else if (beat && sof &&
             (state == ST_ARGMAX || state == ST_OUTPUT))
      ovr <= 1'b1;
    else if (m_result_valid && m_result_ready)
      ovr <= 1'b0;
  end

  video_mnist_result_argmax #(
    .CLASS_NUM   (CLASS_NUM),
    .CLASS_WIDTH (CLASS_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_argmax (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .count_array (cnt),
    .done        (done),
    .index       (arg_index),
    .count       (arg_count)
  );

endmodule

// File: tb/tb_video_mnist_result_collector.sv
// Randomized bench for the MNIST result collector.
// A second instance with 4-bit counters covers saturation.
module tb_video_mnist_result_collector;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [10:0] x0, x1;
  logic [9:0] y0, y1;
  logic [0:0] tuser = '0;
  logic tlast = 1'b0;
  logic [9:0] tdata = '0;
  logic tvalid = 1'b0;
  logic tready, tready_s;
  logic [3:0] r_class, s_class;
  logic [15:0] r_count;
  logic [3:0] s_count;
  logic r_ovr, s_ovr, r_valid, s_valid;
  logic r_ready = 1'b1;
  logic closing = 1'b0;

  int wx0, wx1, wy0, wy1;
  int fw, fh;
  logic [9:0] pix [0:15][0:15];
  int checks = 0;
  int fails = 0;
  int cyc = 0;

  assign x0 = 11'(wx0);
  assign x1 = 11'(wx1);
  assign y0 = 10'(wy0);
  assign y1 = 10'(wy1);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  video_mnist_result_collector dut (
    .clk(clk), .reset(reset),
    .param_x0(x0), .param_x1(x1),
    .param_y0(y0), .param_y1(y1),
    .s_axi4s_tuser(tuser), .s_axi4s_tlast(tlast),
    .s_axi4s_tdata(tdata), .s_axi4s_tvalid(tvalid),
    .s_axi4s_tready(tready),
    .m_result_class(r_class), .m_result_count(r_count),
    .m_result_overrun(r_ovr), .m_result_valid(r_valid),
    .m_result_ready(r_ready)
  );

  video_mnist_result_collector #(.COUNT_WIDTH(4)) dut_s (
    .clk(clk), .reset(reset),
    .param_x0(x0), .param_x1(x1),
    .param_y0(y0), .param_y1(y1),
    .s_axi4s_tuser(tuser), .s_axi4s_tlast(tlast),
    .s_axi4s_tdata(tdata), .s_axi4s_tvalid(tvalid),
    .s_axi4s_tready(tready_s),
    .m_result_class(s_class), .m_result_count(s_count),
    .m_result_overrun(s_ovr), .m_result_valid(s_valid),
    .m_result_ready(r_ready)
  );

  typedef struct {
    logic [3:0] cls;
    logic [15:0] cnt;
    logic ovr;
    logic [3:0] scls;
    logic [3:0] scnt;
    logic sovr;
    logic svld;
  } res_t;

  res_t res_q[$];
  int close_q[$];
  int rise_q[$];
  int len_q[$];

  int vlen = 0;
  logic vprev = 1'b0;
  logic rprev = 1'b0;
  logic [3:0] hcls;
  logic [15:0] hcnt;

  // mid-cycle observer: handshakes, valid pulses, hold stability
  always @(negedge clk) begin
    if (reset) begin
      vprev = 1'b0;
      vlen = 0;
    end else begin
      if (tvalid && tready && closing)
        close_q.push_back(cyc);
      if (r_valid && !vprev)
        rise_q.push_back(cyc);
      if (r_valid) vlen++;
      if (!r_valid && vprev) begin
        len_q.push_back(vlen);
        vlen = 0;
      end
      if (vprev && !rprev) begin
        checks++;
        if (!r_valid || r_class !== hcls ||
            r_count !== hcnt) begin
          fails++;
          $display("FAIL hold_stable got v=%b c=%0d n=%0d want v=1 c=%0d n=%0d",
                   r_valid, r_class, r_count, hcls, hcnt);
        end
      end
      if (r_valid && r_ready)
        res_q.push_back('{r_class, r_count, r_ovr,
                          s_class, s_count, s_ovr, s_valid});
      vprev = r_valid;
      rprev = r_ready;
      hcls = r_class;
      hcnt = r_count;
    end
  end

  // reference: tally in-window votes, clip, first maximum wins
  task automatic model(input int maxc,
                       output int cls, output int cnt);
    int v [10];
    int vc;
    for (int c = 0; c < 10; c++) v[c] = 0;
    for (int yy = 0; yy < fh; yy++)
      for (int xx = 0; xx < fw; xx++)
        if (xx >= wx0 && xx <= wx1 &&
            yy >= wy0 && yy <= wy1)
          for (int c = 0; c < 10; c++)
            if (pix[yy][xx][c]) v[c]++;
    cls = 0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      vc = (v[c] > maxc) ? maxc : v[c];
      if (vc > cnt) begin
        cls = c;
        cnt = vc;
      end
    end
  endtask

  task automatic send_beat(input logic sof,
                           input logic last,
                           input logic [9:0] d,
                           input logic mark,
                           input bit gaps);
    tvalid = 1'b1;
    tuser = sof;
    tlast = last;
    tdata = d;
    closing = mark;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    closing = 1'b0;
    tuser = 1'($urandom_range(0, 1));
    tlast = 1'($urandom_range(0, 1));
    tdata = 10'($urandom);
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit mark,
                            input bit gaps);
    for (int yy = 0; yy < fh; yy++)
      for (int xx = 0; xx < fw; xx++)
        send_beat(xx == 0 && yy == 0, xx == fw - 1,
                  pix[yy][xx],
                  mark && xx == fw - 1 && yy == wy1,
                  gaps);
  endtask

  task automatic fill(input logic [9:0] d);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++)
        pix[yy][xx] = d;
  endtask

  task automatic expect_now(output int c, output int n,
                            output int sc, output int sn);
    model(65535, c, n);
    model(15, sc, sn);
  endtask

  task automatic check_result(input string tag,
                              input int ec, input int en,
                              input int esc, input int esn,
                              input logic eovr,
                              input bit chk_lat);
    res_t r;
    int n = 0;
    int cl, rs, ln;
    while ((res_q.size() == 0 || len_q.size() == 0) &&
           n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (res_q.size() == 0 || len_q.size() == 0) begin
      fails++;
      $display("FAIL %s_timeout got no result want one", tag);
      return;
    end
    r = res_q.pop_front();
    ln = len_q.pop_front();
    rs = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
    checks++;
    if (r.cls !== ec[3:0]) begin
      fails++;
      $display("FAIL %s_class got %0d want %0d", tag, r.cls, ec);
    end
    checks++;
    if (r.cnt !== en[15:0]) begin
      fails++;
      $display("FAIL %s_count got %0d want %0d", tag, r.cnt, en);
    end
    checks++;
    if (r.ovr !== eovr) begin
      fails++;
      $display("FAIL %s_overrun got %b want %b", tag, r.ovr, eovr);
    end
    checks++;
    if (r.svld !== 1'b1 || r.scls !== esc[3:0] ||
        r.scnt !== esn[3:0] || r.sovr !== eovr) begin
      fails++;
      $display("FAIL %s_sat4 got v=%b c=%0d n=%0d o=%b want v=1 c=%0d n=%0d o=%b",
               tag, r.svld, r.scls, r.scnt, r.sovr, esc, esn, eovr);
    end
    if (chk_lat) begin
      cl = (close_q.size() > 0) ? close_q.pop_front() : -100;
      checks++;
      if (rs - cl != 11) begin
        fails++;
        $display("FAIL %s_latency got %0d want 11", tag, rs - cl);
      end
      checks++;
      if (ln != 1) begin
        fails++;
        $display("FAIL %s_valid_len got %0d want 1", tag, ln);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (tready !== 1'b0 || r_valid !== 1'b0 ||
        r_class !== 4'd0 || r_count !== 16'd0 ||
        r_ovr !== 1'b0) begin
      fails++;
      $display("FAIL reset_values got r=%b v=%b c=%0d n=%0d o=%b want all 0",
               tready, r_valid, r_class, r_count, r_ovr);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (tready !== 1'b1 || r_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release got r=%b v=%b want r=1 v=0",
               tready, r_valid);
    end
  endtask

  task automatic test_basic();
    int c, n, sc, sn;
    fw = 8; fh = 4;
    wx0 = 2; wx1 = 5; wy0 = 1; wy1 = 2;
    fill(10'h008);
    expect_now(c, n, sc, sn);
    send_frame(1'b1, 1'b0);
    check_result("basic", c, n, sc, sn, 1'b0, 1'b1);
  endtask

  task automatic test_tie();
    int c, n, sc, sn;
    fw = 8; fh = 4;
    wx0 = 2; wx1 = 6; wy0 = 1; wy1 = 2;
    fill(10'h001);
    for (int xx = 2; xx <= 6; xx++) begin
      pix[1][xx] = 10'h080;
      pix[2][xx] = 10'h004;
    end
    expect_now(c, n, sc, sn);
    send_frame(1'b1, 1'b0);
    check_result("tie", c, n, sc, sn, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int c, n, sc, sn;
    for (int f = 0; f < 6; f++) begin
      wy1 = $urandom_range(0, 5);
      fh = wy1 + 1 + $urandom_range(0, 1);
      wy0 = $urandom_range(0, wy1 + 1);
      fw = $urandom_range(3, 12);
      wx0 = $urandom_range(0, fw);
      wx1 = $urandom_range(0, fw);
      for (int yy = 0; yy < 16; yy++)
        for (int xx = 0; xx < 16; xx++)
          pix[yy][xx] = ($urandom_range(0, 4) == 0) ?
            10'h000 : 10'($urandom);
      expect_now(c, n, sc, sn);
      send_frame(1'b1, 1'b1);
      check_result($sformatf("rand%0d", f),
                   c, n, sc, sn, 1'b0, 1'b1);
    end
  endtask

  task automatic test_sof_restart();
    int c, n, sc, sn;
    fw = 8; fh = 3;
    wx0 = 0; wx1 = 7; wy0 = 0; wy1 = 2;
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 0; xx < 8; xx++)
        if (yy == 0 || xx < 3)
          send_beat(xx == 0 && yy == 0, xx == 7,
                    10'h220, 1'b0, 1'b0);
    fill(10'h200);
    expect_now(c, n, sc, sn);
    send_frame(1'b1, 1'b0);
    check_result("sof_restart", c, n, sc, sn, 1'b0, 1'b1);
  endtask

  task automatic test_saturate();
    int c, n, sc, sn;
    fw = 10; fh = 2;
    wx0 = 0; wx1 = 9; wy0 = 0; wy1 = 1;
    fill(10'h002);
    expect_now(c, n, sc, sn);
    send_frame(1'b1, 1'b0);
    check_result("saturate", c, n, sc, sn, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    int c, n, sc, sn;
    int k = 0;
    fw = 6; fh = 3;
    wx0 = 1; wx1 = 4; wy0 = 0; wy1 = 2;
    r_ready = 1'b0;
    fill(10'h010);
    pix[1][2] = 10'h102;
    expect_now(c, n, sc, sn);
    send_frame(1'b0, 1'b0);
    while (!r_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (r_valid !== 1'b1 || r_ovr !== 1'b0) begin
      fails++;
      $display("FAIL ovr_held got v=%b o=%b want v=1 o=0",
               r_valid, r_ovr);
    end
    fill(10'h001);
    send_frame(1'b0, 1'b0);
    checks++;
    if (r_valid !== 1'b1 || r_ovr !== 1'b1 ||
        r_class !== c[3:0]) begin
      fails++;
      $display("FAIL ovr_flag got v=%b o=%b c=%0d want v=1 o=1 c=%0d",
               r_valid, r_ovr, r_class, c);
    end
    repeat (20) @(posedge clk);
    #1;
    r_ready = 1'b1;
    check_result("ovr_first", c, n, sc, sn, 1'b1, 1'b0);
    fill(10'h040);
    expect_now(c, n, sc, sn);
    send_frame(1'b1, 1'b0);
    check_result("ovr_next", c, n, sc, sn, 1'b0, 1'b1);
    fh = 3;
    fill(10'h100);
    expect_now(c, n, sc, sn);
    send_frame(1'b1, 1'b0);
    fill(10'h001);
    send_frame(1'b0, 1'b0);
    check_result("ovr_argmax", c, n, sc, sn, 1'b1, 1'b1);
    fill(10'h020);
    expect_now(c, n, sc, sn);
    send_frame(1'b1, 1'b0);
    check_result("ovr_clear", c, n, sc, sn, 1'b0, 1'b1);
  endtask

  task automatic test_reset_argmax();
    int c, n, sc, sn;
    fw = 5; fh = 2;
    wx0 = 0; wx1 = 4; wy0 = 0; wy1 = 1;
    fill(10'h080);
    send_frame(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (tready !== 1'b0 || r_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_async got r=%b v=%b want r=0 v=0",
               tready, r_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (r_valid !== 1'b0 || rise_q.size() != 0) begin
      fails++;
      $display("FAIL rst_no_result got v=%b rises=%0d want v=0 rises=0",
               r_valid, rise_q.size());
    end
    fill(10'h004);
    pix[0][3] = 10'h010;
    pix[1][1] = 10'h010;
    pix[1][2] = 10'h010;
    expect_now(c, n, sc, sn);
    send_frame(1'b1, 1'b1);
    check_result("rst_after", c, n, sc, sn, 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wx0 = 0; wx1 = 0; wy0 = 0; wy1 = 0;
    fw = 1; fh = 1;
    test_reset();
    test_basic();
    test_tie();
    test_random();
    test_sof_restart();
    test_saturate();
    test_overrun();
    test_reset_argmax();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
